// File: rtl/pri_sel_pkg.sv
// Shared constants and types for the priority-select pipeline.
// PRI_W / PTR_W are the priority and round-robin pointer widths for the
// default geometry (N_DEF channels, P_DEF priority levels); pri_vec_t is
// the matching per-channel priority vector.
package pri_sel_pkg;

  localparam int N_DEF = 8;
  localparam int P_DEF = 16;
  localparam int PRI_W = $clog2(P_DEF);
  localparam int PTR_W = $clog2(N_DEF);

  typedef logic [PRI_W-1:0] pri_t;
  typedef pri_t pri_vec_t [0:N_DEF-1];

endpackage

// File: rtl/pri_sel_pipe_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Grants the lowest set bit of req at an index >= ptr; when there is none,
// wraps and grants the lowest set bit overall. The result is zero when req
// is zero.
//   req : N-bit request mask
//   ptr : starting index for the search
//   gnt : one-hot grant, or zero
module rr_pick
  import pri_sel_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] hi_mask;
  logic [N-1:0] masked;
  logic [N-1:0] sel;

  always_comb begin
    hi_mask = {N{1'b1}} << ptr;
    masked  = req & hi_mask;
    sel     = (masked != '0) ? masked : req;
    // x & -x isolates the lowest set bit.
    gnt     = sel & (~sel + ONE);
  end

endmodule

// File: rtl/pri_sel_pipe.sv
// pri_sel_pipe: pipelined maximum-priority selector with round-robin grant.
// A binary max tree is registered one level per stage ($clog2(N) stages),
// with the original priority vector carried alongside. A final stage
// registers the maximum and the tie mask. The grant is picked from that
// mask using the live round-robin pointer, so an accept takes effect on the
// very next result. Latency from sampled in_valid to out_valid is
// $clog2(N)+1 cycles; a new vector is accepted every cycle.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : in_pri is valid this cycle
//   in_pri     : per-channel priority, 0 = no request
//   out_valid  : result valid
//   out_pri    : maximum priority of the vector
//   out_req    : all channels tied at out_pri (zero when out_pri is 0)
//   out_gnt    : one-hot round-robin pick among out_req, or zero
//   out_accept : consumer took out_gnt; advances the pointer
module pri_sel_pipe
  import pri_sel_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int P = P_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [$clog2(P)-1:0] in_pri [0:N-1],
  output logic                 out_valid,
  output logic [$clog2(P)-1:0] out_pri,
  output logic [N-1:0]         out_req,
  output logic [N-1:0]         out_gnt,
  input  logic                 out_accept
);

  localparam int W    = $clog2(P);
  localparam int PW   = $clog2(N);
  localparam int LVLS = PW;

  function automatic logic [W-1:0] pri_max(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  genvar l;
  for (l = 0; l < LVLS; l++) begin : g_lvl
    localparam int CNT = N >> (l + 1);

    logic [W-1:0] src_mx  [0:2*CNT-1];
    logic [W-1:0] src_vec [0:N-1];
    logic         src_vld;

    logic [W-1:0] mx_p  [0:CNT-1];
    logic [W-1:0] vec_p [0:N-1];
    logic         vld_p;

    if (l == 0) begin : g_src_in
      assign src_mx  = in_pri;
      assign src_vec = in_pri;
      assign src_vld = in_valid;
    end else begin : g_src_lvl
      assign src_mx  = g_lvl[l-1].mx_p;
      assign src_vec = g_lvl[l-1].vec_p;
      assign src_vld = g_lvl[l-1].vld_p;
    end

    // ---- tree level l: pairwise max, vector carried unchanged ----
    always_ff @(posedge clk) begin
      if (rst) vld_p <= 1'b0;
      else     vld_p <= src_vld;
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < CNT; i++) begin
        mx_p[i] <= pri_max(src_mx[2*i], src_mx[2*i+1]);
      end
      vec_p <= src_vec;
    end
  end

  logic [W-1:0] top_max;
  logic [W-1:0] top_vec [0:N-1];
  logic         top_vld;
  logic [N-1:0] tie;

  assign top_max = g_lvl[LVLS-1].mx_p[0];
  assign top_vec = g_lvl[LVLS-1].vec_p;
  assign top_vld = g_lvl[LVLS-1].vld_p;

  always_comb begin
    tie = '0;
    for (int i = 0; i < N; i++) begin
      tie[i] = (top_vec[i] == top_max) && (top_max != '0);
    end
  end

  // ---- final stage: maximum and tie mask ----
  logic         vld_pf;
  logic [W-1:0] pri_pf;
  logic [N-1:0] req_pf;

  always_ff @(posedge clk) begin
    if (rst) vld_pf <= 1'b0;
    else     vld_pf <= top_vld;
  end

  always_ff @(posedge clk) begin
    pri_pf <= top_max;
    req_pf <= tie;
  end

  // Data registers are not reset, so results are gated by the valid bit.
  assign out_valid = vld_pf;
  assign out_pri   = vld_pf ? pri_pf : '0;
  assign out_req   = vld_pf ? req_pf : '0;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;

  rr_pick #(.N(N)) u_rr_pick (
    .req (out_req),
    .ptr (ptr),
    .gnt (out_gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (out_gnt[i]) gnt_idx = PW'(i);
    end
  end

  // N is a power of two, so the increment wraps N-1 back to 0 by itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (out_valid && out_accept && (out_gnt != '0)) begin
      ptr <= gnt_idx + PW'(1);
    end
  end

endmodule

// File: tb/tb_pri_sel_pipe.sv
// Testbench for pri_sel_pipe (N=8, P=16, latency 4): directed vectors with
// hand-computed results, then a long random run against a reference model.
module tb_pri_sel_pipe;
  import pri_sel_pkg::*;

  localparam int N = 8;
  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  pri_vec_t   in_pri;
  logic       out_valid;
  pri_t       out_pri;
  logic [N-1:0] out_req;
  logic [N-1:0] out_gnt;
  logic       out_accept;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pri_sel_pipe #(.N(N), .P(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_pri     (in_pri),
    .out_valid  (out_valid),
    .out_pri    (out_pri),
    .out_req    (out_req),
    .out_gnt    (out_gnt),
    .out_accept (out_accept)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] p,
                         input logic [7:0] r, input logic [7:0] g);
    chk({tag, "_vld"}, 32'(out_valid), 32'(v));
    chk({tag, "_pri"}, 32'(out_pri),   32'(p));
    chk({tag, "_req"}, 32'(out_req),   32'(r));
    chk({tag, "_gnt"}, 32'(out_gnt),   32'(g));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input pri_vec_t p);
    in_valid = v;
    in_pri   = p;
  endtask

  // Reference model
  function automatic logic [3:0] m_max(input pri_vec_t p);
    logic [3:0] m = '0;
    for (int i = 0; i < N; i++) if (p[i] > m) m = p[i];
    return m;
  endfunction

  function automatic logic [7:0] m_req(input pri_vec_t p, input logic [3:0] mx);
    logic [7:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (mx != 0) && (p[i] == mx);
    return r;
  endfunction

  function automatic logic [7:0] m_gnt(input logic [7:0] r, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx = (ptr + k) % N;
      if (r[idx]) return 8'(1) << idx;
    end
    return 8'h00;
  endfunction

  function automatic int m_idx(input logic [7:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  typedef struct {
    logic     v;
    pri_vec_t p;
  } ent_t;

  ent_t       q[$];
  pri_vec_t   z, va, v2, v3, v4, v5a, v5b;
  logic [7:0] g2 [0:3];
  int         m_ptr;

  initial begin
    z   = '{default: 4'd0};
    va  = '{4'd3, 4'd0, 4'd7, 4'd1, 4'd0, 4'd2, 4'd0, 4'd5};
    v2  = '{4'd9, 4'd0, 4'd0, 4'd9, 4'd0, 4'd0, 4'd9, 4'd0};
    v3  = '{4'd5, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0};
    v4  = '{4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0};
    v5a = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
    v5b = '{4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2};
    g2  = '{8'h01, 8'h08, 8'h40, 8'h01};

    rst = 1'b1; out_accept = 1'b0;
    drive(1'b0, z);
    repeat (3) cyc();
    chk_out("rst", 1'b0, 4'd0, 8'h00, 8'h00);
    rst = 1'b0;
    cyc();

    // Single maximum, exact latency
    drive(1'b1, va); cyc();
    drive(1'b0, z);  cyc(); cyc();
    chk("t1_early_vld", 32'(out_valid), 32'd0);
    cyc();
    chk_out("t1", 1'b1, 4'd7, 8'h04, 8'h04);
    cyc();
    chk("t1_after_vld", 32'(out_valid), 32'd0);

    // Round-robin rotation with accept on every result
    for (int i = 0; i < 4; i++) begin drive(1'b1, v2); cyc(); end
    drive(1'b0, z);
    for (int j = 0; j < 4; j++) begin
      chk_out("t2", 1'b1, 4'd9, 8'h49, g2[j]);
      out_accept = 1'b1;
      cyc();
    end
    out_accept = 1'b0;
    chk("t2_tail_vld", 32'(out_valid), 32'd0);

    // All-zero vector then bubble; accept must be ignored (ptr stays 1)
    drive(1'b1, z); cyc();
    drive(1'b0, z); cyc(); cyc(); cyc();
    chk_out("t3_zero", 1'b1, 4'd0, 8'h00, 8'h00);
    out_accept = 1'b1;
    cyc();
    chk_out("t3_bub", 1'b0, 4'd0, 8'h00, 8'h00);
    cyc();
    out_accept = 1'b0;
    drive(1'b1, v3); cyc();
    drive(1'b0, z);  cyc(); cyc(); cyc();
    chk_out("t3_ptr", 1'b1, 4'd5, 8'h09, 8'h08);

    // Accept held low: same grant every time
    for (int i = 0; i < 3; i++) begin drive(1'b1, v4); cyc(); end
    drive(1'b0, z); cyc();
    for (int j = 0; j < 3; j++) begin
      chk_out("t4", 1'b1, 4'd4, 8'h24, 8'h04);
      cyc();
    end
    chk("t4_tail_vld", 32'(out_valid), 32'd0);

    // Reset mid-stream (ptr is 1 going in)
    drive(1'b1, v5a); cyc();
    drive(1'b1, v5a); cyc();
    rst = 1'b1;
    drive(1'b1, v5a); cyc();
    chk_out("t5_in_rst", 1'b0, 4'd0, 8'h00, 8'h00);
    rst = 1'b0;
    drive(1'b1, v5b); cyc();
    drive(1'b0, z);
    chk("t5_drop0_vld", 32'(out_valid), 32'd0); cyc();
    chk("t5_drop1_vld", 32'(out_valid), 32'd0); cyc();
    chk("t5_drop2_vld", 32'(out_valid), 32'd0); cyc();
    chk_out("t5_post", 1'b1, 4'd2, 8'h81, 8'h01);

    // Random throughput against the reference model
    out_accept = 1'b0;
    m_ptr = 0;
    repeat (5) cyc();
    for (int i = 0; i < 4; i++) q.push_back('{v: 1'b0, p: z});
    for (int it = 0; it < 10004; it++) begin
      ent_t       e, ne;
      logic [3:0] mx;
      logic [7:0] rq, gn;
      logic       acc;
      int         hi;
      cyc();
      e  = q.pop_front();
      mx = '0; rq = '0; gn = '0;
      if (e.v) begin
        mx = m_max(e.p);
        rq = m_req(e.p, mx);
        gn = m_gnt(rq, m_ptr);
      end
      chk_out("rnd", e.v, mx, rq, gn);
      acc = 1'($urandom_range(0, 1));
      out_accept = acc;
      if (e.v && acc && gn != 8'h00) m_ptr = (m_idx(gn) + 1) % N;
      ne.v = (it < 10000);
      hi   = ($urandom_range(0, 1) == 0) ? 3 : 15;
      for (int k = 0; k < N; k++) ne.p[k] = ne.v ? 4'($urandom_range(0, hi)) : 4'd0;
      drive(ne.v, ne.p);
      q.push_back(ne);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
